// File: rtl/mux4_rr_sel_arbiter.sv
// mux4_rr_sel_arbiter: round-robin arbiter driving the 2-bit select of a
// 4-input data mux. It holds sel/gnt for a burst and releases on last beat,
// on hold limit (MAX_HOLD accepted beats), or when the grantee drops req.
// Optional build macro MUX4_ARB_PRIO0_EN: channel 0 wins every arbitration
// it takes part in (it never preempts an active grant).
module mux4_rr_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       last,
  input  logic       ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       gnt_valid
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic       w_beat;
  logic       w_drop;
  logic       w_release;
  logic [1:0] w_next_ptr;
  logic [1:0] w_arb_ptr;
  logic [1:0] w_idx;
  logic [1:0] w_win;
  logic       w_found;

  // Release qualification: a withdrawn grantee releases regardless of ready
  assign w_beat     = (r_state == S_GRANT) & ready;
  assign w_drop     = ~req[sel];
  assign w_release  = (r_state == S_GRANT) &
                      (w_drop | (w_beat & last) | (w_beat & (r_cnt == HOLD_LAST)));
  assign w_next_ptr = sel + 2'd1;
  assign w_arb_ptr  = w_release ? w_next_ptr : r_ptr;

  // Winner search from w_arb_ptr upwards mod 4; lowest offset wins
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = w_arb_ptr + 2'(i);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`ifdef MUX4_ARB_PRIO0_EN
    if (req[0]) begin
      w_found = 1'b1;
      w_win   = 2'd0;
    end
`endif
  end

  // Grant FSM with registered sel/gnt/gnt_valid, pointer and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
      sel       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_GRANT;
            sel       <= w_win;
            gnt       <= 4'b0001 << w_win;
            gnt_valid <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_ptr <= w_next_ptr;
            r_cnt <= '0;
            if (w_found) begin
              sel <= w_win;
              gnt <= 4'b0001 << w_win;
            end else begin
              r_state   <= S_IDLE;
              gnt       <= 4'b0000;
              gnt_valid <= 1'b0;
            end
          end else if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_sel_arbiter.sv
// Testbench for mux4_rr_sel_arbiter: directed scenarios plus randomized
// traffic compared against an integer-level model of the arbitration rules.
module tb_mux4_rr_sel_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       last;
  logic       ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: who owns the datapath, beats taken, rotation start
  int m_busy;
  int m_owner;
  int m_ptr;
  int m_beats;

  always #5 clk = ~clk;

  mux4_rr_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .ready(ready),
    .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid)
  );

  function automatic int pick(input int r, input int p);
`ifdef MUX4_ARB_PRIO0_EN
    if ((r & 1) != 0) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (((r >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
  endtask

  task automatic model_step(input int r, input int l, input int rd);
    int rel;
    int w;
    if (m_busy == 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_beats = 0;
      end
    end else begin
      rel = 0;
      if (((r >> m_owner) & 1) == 0) rel = 1;
      else if (rd != 0) begin
        m_beats = m_beats + 1;
        if (l != 0 || m_beats == int'(MAX_HOLD)) rel = 1;
      end
      if (rel != 0) begin
        m_ptr = (m_owner + 1) % 4;
        w = pick(r, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_beats = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, settle 1ns
  task automatic drive(input logic [3:0] r, input logic l, input logic rd);
    @(negedge clk);
    req = r; last = l; ready = rd;
    @(posedge clk);
    model_step(int'(r), int'(l), int'(rd));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b0000; last = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b1111; last = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", gnt_valid); end
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0000;
    model_reset();
    drive(4'b0001, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b1);
    repeat (2) begin
      drive(4'b0000, 1'b0, 1'b1);
      checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
        errors++; $display("FAIL idle_after_release: got gnt=%b valid=%b expected 0000/0", gnt, gnt_valid);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0100, 1'b0, 1'b0);
    checks++; if (gnt !== 4'b0100 || sel !== 2'd2 || gnt_valid !== 1'b1) begin
      errors++; $display("FAIL single_grant: got gnt=%b sel=%0d valid=%b expected 0100/2/1", gnt, sel, gnt_valid);
    end
    drive(4'b0100, 1'b0, 1'b1);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_hold: got %b expected 0100", gnt); end
    drive(4'b0100, 1'b1, 1'b1);
    checks++; if (gnt !== 4'b0100 || gnt_valid !== 1'b1) begin
      errors++; $display("FAIL single_regrant: got gnt=%b valid=%b expected 0100/1", gnt, gnt_valid);
    end
    drive(4'b0000, 1'b0, 1'b0);
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: got gnt=%b valid=%b expected 0000/0", gnt, gnt_valid);
    end
    drive(4'b1111, 1'b0, 1'b0);
    checks++; if (gnt !== 4'b1000 || sel !== 2'd3) begin
      errors++; $display("FAIL single_ptr3: got gnt=%b sel=%0d expected 1000/3", gnt, sel);
    end
  endtask

  task automatic test_rotation();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b1, 1'b1);
      checks++; if (gnt_valid !== 1'b1 || int'(sel) != exp_order[i]) begin
        errors++; $display("FAIL rotation[%0d]: got sel=%0d valid=%b expected %0d/1", i, sel, gnt_valid, exp_order[i]);
      end
    end
  endtask

  task automatic test_hold();
    int beats [$];
    int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic rd;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rd = ((i % 3) != 2);
      if (gnt_valid === 1'b1 && rd) beats.push_back(int'(sel));
      drive(4'b0011, 1'b0, rd);
    end
    checks++; if (beats.size() < 9) begin
      errors++; $display("FAIL hold_count: got %0d beats expected at least 9", beats.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++; if (beats[i] != exp_seq[i]) begin
          errors++; $display("FAIL hold_beat[%0d]: got ch%0d expected ch%0d", i, beats[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_drop_async();
    do_reset();
    drive(4'b0010, 1'b0, 1'b1);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_grant1: got %b expected 0010", gnt); end
    drive(4'b0010, 1'b0, 1'b1);
    drive(4'b1001, 1'b0, 1'b1);
    checks++; if (gnt !== 4'b1000 || sel !== 2'd3) begin
      errors++; $display("FAIL drop_move: got gnt=%b sel=%0d expected 1000/3", gnt, sel);
    end
    drive(4'b1001, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || sel !== 2'd0) begin
      errors++; $display("FAIL async_reset: got gnt=%b valid=%b sel=%0d expected 0000/0/0", gnt, gnt_valid, sel);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0000;
    model_reset();
  endtask

  task automatic test_prio();
    do_reset();
    drive(4'b0010, 1'b0, 1'b1);
    drive(4'b1101, 1'b0, 1'b1);
`ifdef MUX4_ARB_PRIO0_EN
    checks++; if (sel !== 2'd0 || gnt !== 4'b0001) begin
      errors++; $display("FAIL prio_winner: got sel=%0d gnt=%b expected 0/0001", sel, gnt);
    end
`else
    checks++; if (sel !== 2'd2 || gnt !== 4'b0100) begin
      errors++; $display("FAIL rr_winner: got sel=%0d gnt=%b expected 2/0100", sel, gnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r = 4'b0000;
      drive(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      eg = (m_busy != 0) ? 4'(1 << m_owner) : 4'b0000;
      checks++; if (gnt !== eg || gnt_valid !== 1'(m_busy)) begin
        errors++; $display("FAIL random[%0d]: got gnt=%b valid=%b expected %b/%0d", i, gnt, gnt_valid, eg, m_busy);
      end
      if (m_busy != 0) begin
        checks++; if (int'(sel) != m_owner) begin
          errors++; $display("FAIL random_sel[%0d]: got %0d expected %0d", i, sel, m_owner);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; last = 1'b0; ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_hold();
    test_drop_async();
    test_prio();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
